// File: rtl/spi_controller_if.sv
// Host-side request and serial-line bundle for spi_controller.
// master is the controller's view; slave is the requesting host's view.
interface spi_controller_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              SCLK;
  logic              COPI;
  logic              nCS;
  logic              busy;
  logic              done;

  modport master (
    input  start, write, addr, wdata,
    output SCLK, COPI, nCS, busy, done
  );

  modport slave (
    output start, write, addr, wdata,
    input  SCLK, COPI, nCS, busy, done
  );
endinterface

// File: rtl/spi_controller.sv
// Write-only SPI controller: shifts a 16-bit {write, addr, wdata} frame MSB first,
// mode-0 timing, then holds nCS low one half-period and enforces an nCS-high gap.
module spi_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_controller_if.master  bus
);
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;

  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [FRAME_W-1:0] shreg_q, shreg_n;
  logic [CNT_W-1:0]   div_q,   div_n;
  logic [BIT_W-1:0]   bit_q,   bit_n;
  logic               sclk_q,  sclk_n;
  logic               ncs_q,   ncs_n;
  logic               busy_q,  busy_n;
  logic               done_q,  done_n;

  // COPI is the shift register MSB; the register is fully emptied by the time HOLD starts
  assign bus.COPI = shreg_q[FRAME_W-1];
  assign bus.SCLK = sclk_q;
  assign bus.nCS  = ncs_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      sclk_q  <= sclk_n;
      ncs_q   <= ncs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic; every output flop is loaded from here
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    div_n   = div_q;
    bit_n   = bit_q;
    sclk_n  = sclk_q;
    ncs_n   = ncs_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = SHIFT_LO;
          shreg_n = {bus.write, bus.addr, bus.wdata};
          div_n   = DIV_RELOAD;
          bit_n   = '0;
          sclk_n  = 1'b0;
          ncs_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (div_q == '0) begin
          state_n = SHIFT_HI;
          sclk_n  = 1'b1;
          div_n   = DIV_RELOAD;
        end else begin
          div_n = div_q - CNT_W'(1);
        end
      end

      SHIFT_HI: begin
        if (div_q == '0) begin
          // shifting on the falling edge presents the next bit at the start of its low phase
          shreg_n = {shreg_q[FRAME_W-2:0], 1'b0};
          sclk_n  = 1'b0;
          div_n   = DIV_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_n = HOLD;
          end else begin
            state_n = SHIFT_LO;
            bit_n   = bit_q + BIT_W'(1);
          end
        end else begin
          div_n = div_q - CNT_W'(1);
        end
      end

      HOLD: begin
        if (div_q == '0) begin
          state_n = GAP;
          ncs_n   = 1'b1;
          div_n   = GAP_RELOAD;
        end else begin
          div_n = div_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (div_q == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          bit_n   = '0;
        end else begin
          div_n = div_q - CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        shreg_n = '0;
        div_n   = '0;
        bit_n   = '0;
        sclk_n  = 1'b0;
        ncs_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: two instances (CLK_DIV=4/GAP=16 and CLK_DIV=2/GAP=1)
// observed by a 3-flop synchronised SPI receiver model plus nCS/SCLK/done timing monitors.
module tb_spi_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_controller_if bus4();
  spi_controller_if bus2();

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(16)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  spi_controller #(.CLK_DIV(2), .GAP_CYCLES(1))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    int          dut;
    logic [15:0] data;
    int          bits;
    int          low_len;
    int          gap;      // -1: preceding nCS-high time not checked
  } frame_t;

  typedef struct {
    int dut;
    int at;
  } done_t;

  frame_t frame_q[$];
  done_t  done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic int cd_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  // ---------------------------------------------------------------- monitors
  logic [1:0] m_sclk, m_copi, m_ncs, m_done, m_busy;
  assign m_sclk = {bus2.SCLK, bus4.SCLK};
  assign m_copi = {bus2.COPI, bus4.COPI};
  assign m_ncs  = {bus2.nCS,  bus4.nCS};
  assign m_done = {bus2.done, bus4.done};
  assign m_busy = {bus2.busy, bus4.busy};

  logic        ps[2]       = '{1'b0, 1'b0};
  logic        pc[2]       = '{1'b0, 1'b0};
  logic        pn[2]       = '{1'b1, 1'b1};
  logic        copi_bad[2] = '{1'b0, 1'b0};
  int          low_cnt[2]  = '{0, 0};
  int          high_cnt[2] = '{0, 0};
  int          last_low[2] = '{0, 0};
  int          last_gap[2] = '{0, 0};
  int          hi_cnt[2]   = '{0, 0};
  int          since[2]    = '{0, 0};
  int          rises[2]    = '{0, 0};
  logic [3:0]  ss[2]       = '{4'h0, 4'h0};
  logic [3:0]  sc[2]       = '{4'h0, 4'h0};
  logic [3:0]  sn[2]       = '{4'hF, 4'hF};
  logic [15:0] rx_sh[2]    = '{16'h0, 16'h0};
  int          rx_bits[2]  = '{0, 0};

  always @(negedge clk) begin
    frame_t f;
    done_t  dn;
    for (int i = 0; i < 2; i++) begin
      // nCS low/high run lengths
      if (m_ncs[i]) begin
        high_cnt[i] <= high_cnt[i] + 1;
        low_cnt[i]  <= 0;
        rises[i]    <= 0;
        if (!pn[i]) last_low[i] <= low_cnt[i];
      end else begin
        low_cnt[i]  <= low_cnt[i] + 1;
        high_cnt[i] <= 0;
        if (pn[i]) last_gap[i] <= high_cnt[i];
      end

      // SCLK phase lengths and COPI stability while SCLK is high
      if (m_sclk[i] && !ps[i]) begin
        if (!m_ncs[i] && rises[i] > 0) chk("sclk rise-to-rise", since[i], 2 * cd_of(i));
        rises[i] <= rises[i] + 1;
        since[i] <= 1;
      end else begin
        since[i] <= since[i] + 1;
      end
      if (m_sclk[i]) hi_cnt[i] <= hi_cnt[i] + 1;
      else           hi_cnt[i] <= 0;
      if (m_sclk[i] && ps[i] && (m_copi[i] != pc[i])) copi_bad[i] <= 1'b1;
      if (!m_sclk[i] && ps[i]) begin
        chk("sclk high length", hi_cnt[i], cd_of(i));
        chk("copi stable while sclk high", int'(copi_bad[i]), 0);
        copi_bad[i] <= 1'b0;
      end

      // done pulses against the scoreboard
      if (m_done[i]) begin
        chk("busy low in done cycle", int'(m_busy[i]), 0);
        if (done_q.size() == 0) begin
          chk("unexpected done pulse on dut", i, -1);
        end else begin
          dn = done_q.pop_front();
          chk("done dut", i, dn.dut);
          chk("done cycle", cyc, dn.at);
        end
      end

      // 3-flop synchronised receiver: sample COPI on synchronised SCLK rise
      ss[i] <= {ss[i][2:0], m_sclk[i]};
      sc[i] <= {sc[i][2:0], m_copi[i]};
      sn[i] <= {sn[i][2:0], m_ncs[i]};
      if (!sn[i][2] && ss[i][2] && !ss[i][3]) begin
        rx_sh[i]   <= {rx_sh[i][14:0], sc[i][2]};
        rx_bits[i] <= rx_bits[i] + 1;
      end
      if (sn[i][2] && !sn[i][3]) begin
        if (frame_q.size() == 0) begin
          chk("unexpected frame on dut", i, -1);
        end else begin
          f = frame_q.pop_front();
          chk("frame dut", i, f.dut);
          chk("frame bit count", rx_bits[i], f.bits);
          chk("ncs low cycles", last_low[i], f.low_len);
          if (f.gap >= 0) chk("ncs high between frames", last_gap[i], f.gap);
          if (f.bits == 16) begin
            chk("rx write bit", int'(rx_sh[i][15]), int'(f.data[15]));
            chk("rx addr", int'(rx_sh[i][14:8]), int'(f.data[14:8]));
            chk("rx wdata", int'(rx_sh[i][7:0]), int'(f.data[7:0]));
          end else begin
            chk("rx partial bits", int'(rx_sh[i]), int'(f.data));
          end
        end
        rx_sh[i]   <= 16'h0;
        rx_bits[i] <= 0;
      end

      ps[i] <= m_sclk[i];
      pc[i] <= m_copi[i];
      pn[i] <= m_ncs[i];
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input int d, input logic s, input logic [15:0] f);
    if (d == 0) begin
      bus4.start = s; bus4.write = f[15]; bus4.addr = f[14:8]; bus4.wdata = f[7:0];
    end else begin
      bus2.start = s; bus2.write = f[15]; bus2.addr = f[14:8]; bus2.wdata = f[7:0];
    end
  endtask

  // Called in the cycle whose closing edge accepts the frame (cycle 0).
  task automatic expect_frame(input int d, input logic [15:0] f, input int gap);
    frame_t fr;
    done_t  dn;
    fr.dut = d; fr.data = f; fr.bits = 16; fr.low_len = 33 * cd_of(d); fr.gap = gap;
    frame_q.push_back(fr);
    dn.dut = d; dn.at = cyc + 1 + 33 * cd_of(d) + gap_of(d);
    done_q.push_back(dn);
  endtask

  task automatic wait_idle(input int d);
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = (d == 0) ? !bus4.busy : !bus2.busy;
    end
    if (!ok) chk("idle within 400 cycles on dut", d, -1);
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    if (d == 0) begin
      chk({tag, " nCS"},  int'(bus4.nCS),  1);
      chk({tag, " SCLK"}, int'(bus4.SCLK), 0);
      chk({tag, " COPI"}, int'(bus4.COPI), 0);
      chk({tag, " busy"}, int'(bus4.busy), 0);
      chk({tag, " done"}, int'(bus4.done), 0);
    end else begin
      chk({tag, " nCS"},  int'(bus2.nCS),  1);
      chk({tag, " SCLK"}, int'(bus2.SCLK), 0);
      chk({tag, " COPI"}, int'(bus2.COPI), 0);
      chk({tag, " busy"}, int'(bus2.busy), 0);
      chk({tag, " done"}, int'(bus2.done), 0);
    end
  endtask

  initial begin
    frame_t ab;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset dut4", 0);
    check_idle_outputs("reset dut2", 1);

    // start held during reset is ignored
    drive(0, 1'b1, 16'h84A5);
    repeat (2) @(negedge clk);
    chk("start during reset: nCS", int'(bus4.nCS), 1);
    chk("start during reset: busy", int'(bus4.busy), 0);

    // first cycle after reset release accepts the frame; then start chatter during the frame
    rst_n = 1'b1;
    expect_frame(0, 16'h84A5, -1);
    for (int k = 1; k <= 148; k++) begin
      @(negedge clk);
      drive(0, (k >= 2) && (k % 2 == 1), 16'($urandom()));
    end
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);

    // start held high across three frames
    repeat (5) @(negedge clk);
    drive(0, 1'b1, 16'h8001);
    expect_frame(0, 16'h8001, -1);
    @(negedge clk);
    drive(0, 1'b1, 16'h837F);
    repeat (148) @(negedge clk);
    expect_frame(0, 16'h837F, 17);
    @(negedge clk);
    drive(0, 1'b1, 16'h0000);
    repeat (148) @(negedge clk);
    expect_frame(0, 16'h0000, 17);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);
    wait_idle(0);

    // reset at cycle 40 abandons the frame after five bits
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 16'hC3A5);
    ab.dut = 0; ab.data = 16'h0018; ab.bits = 5; ab.low_len = 40; ab.gap = -1;
    frame_q.push_back(ab);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort nCS", int'(bus4.nCS), 1);
    chk("abort SCLK", int'(bus4.SCLK), 0);
    chk("abort busy", int'(bus4.busy), 0);
    chk("abort done", int'(bus4.done), 0);
    rst_n = 1'b1;

    // clean read frame after the abort
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 16'h5A3C);
    expect_frame(0, 16'h5A3C, -1);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000);
    wait_idle(0);

    // fastest settings: all-ones frame then an immediate all-zero frame
    repeat (3) @(negedge clk);
    drive(1, 1'b1, 16'hFFFF);
    expect_frame(1, 16'hFFFF, -1);
    @(negedge clk);
    drive(1, 1'b1, 16'h0000);
    repeat (67) @(negedge clk);
    expect_frame(1, 16'h0000, 2);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000);
    wait_idle(1);

    repeat (20) @(negedge clk);
    check_idle_outputs("final dut4", 0);
    check_idle_outputs("final dut2", 1);
    chk("frames left in scoreboard", frame_q.size(), 0);
    chk("done pulses left in scoreboard", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end
endmodule
